// File: rtl/aes_axil_pkg.sv
// Shared definitions for the AES AXI4-Lite command master: FSM encoding,
// AXI response codes and the AES peripheral register map.
package aes_axil_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_RESP,
    S_RD_REQ,
    S_RD_DATA,
    S_RESP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_KEY0   = 8'h10;
  localparam logic [7:0] REG_KEY1   = 8'h14;
  localparam logic [7:0] REG_KEY2   = 8'h18;
  localparam logic [7:0] REG_KEY3   = 8'h1C;
  localparam logic [7:0] REG_DIN0   = 8'h20;
  localparam logic [7:0] REG_DIN1   = 8'h24;
  localparam logic [7:0] REG_DIN2   = 8'h28;
  localparam logic [7:0] REG_DIN3   = 8'h2C;
  localparam logic [7:0] REG_DOUT0  = 8'h30;
  localparam logic [7:0] REG_DOUT1  = 8'h34;
  localparam logic [7:0] REG_DOUT2  = 8'h38;
  localparam logic [7:0] REG_DOUT3  = 8'h3C;
  localparam logic [7:0] REG_STATUS = 8'h40;

endpackage

// File: rtl/aes_axil_master.sv
// Single-outstanding AXI4-Lite master: turns one command into one AXI
// write or read and returns the slave response, with a sticky wait timeout.
module aes_axil_master
  import aes_axil_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES     = 256
) (
  input  logic                              m00_axi_aclk,
  input  logic                              m00_axi_areset,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                        rsp_resp,
  output logic                              timeout,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     m00_axi_awaddr,
  output logic [2:0]                        m00_axi_awprot,
  output logic                              m00_axi_awvalid,
  input  logic                              m00_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     m00_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m00_axi_wstrb,
  output logic                              m00_axi_wvalid,
  input  logic                              m00_axi_wready,
  input  logic [1:0]                        m00_axi_bresp,
  input  logic                              m00_axi_bvalid,
  output logic                              m00_axi_bready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     m00_axi_araddr,
  output logic [2:0]                        m00_axi_arprot,
  output logic                              m00_axi_arvalid,
  input  logic                              m00_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     m00_axi_rdata,
  input  logic [1:0]                        m00_axi_rresp,
  input  logic                              m00_axi_rvalid,
  output logic                              m00_axi_rready
);

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  state_t                            state_q, state_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0]     addr_q;
  logic [C_M_AXI_DATA_WIDTH-1:0]     wdata_q;
  logic [C_M_AXI_DATA_WIDTH/8-1:0]   wstrb_q;
  logic                              aw_done_q, w_done_q;
  logic [C_M_AXI_DATA_WIDTH-1:0]     rdata_q;
  logic [1:0]                        resp_q;
  logic [15:0]                       wait_cnt_q;
  logic                              timeout_q;
  logic                              accept;
  logic                              waiting;

  assign accept  = cmd_valid & cmd_ready;
  assign waiting = (state_q == S_WR_REQ) || (state_q == S_WR_RESP) ||
                   (state_q == S_RD_REQ) || (state_q == S_RD_DATA);

  assign m00_axi_awaddr = addr_q;
  assign m00_axi_araddr = addr_q;
  assign m00_axi_wdata  = wdata_q;
  assign m00_axi_wstrb  = wstrb_q;
  assign m00_axi_awprot = 3'b000;
  assign m00_axi_arprot = 3'b000;
  assign rsp_rdata      = rdata_q;
  assign rsp_resp       = resp_q;
  assign timeout        = timeout_q;

  always_ff @(posedge m00_axi_aclk or posedge m00_axi_areset) begin
    if (m00_axi_areset) state_q <= S_IDLE;
    else                state_q <= state_d;
  end

  // Handshakes are taken from the ready inputs directly so the exit test
  // does not read back outputs driven by this same block.
  always_comb begin
    state_d         = state_q;
    cmd_ready       = 1'b0;
    rsp_valid       = 1'b0;
    m00_axi_awvalid = 1'b0;
    m00_axi_wvalid  = 1'b0;
    m00_axi_bready  = 1'b0;
    m00_axi_arvalid = 1'b0;
    m00_axi_rready  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cmd_ready = ~m00_axi_areset;
        if (cmd_valid && !m00_axi_areset)
          state_d = cmd_write ? S_WR_REQ : S_RD_REQ;
      end
      S_WR_REQ: begin
        m00_axi_awvalid = ~aw_done_q;
        m00_axi_wvalid  = ~w_done_q;
        if ((aw_done_q || m00_axi_awready) && (w_done_q || m00_axi_wready))
          state_d = S_WR_RESP;
      end
      S_WR_RESP: begin
        m00_axi_bready = 1'b1;
        if (m00_axi_bvalid) state_d = S_RESP;
      end
      S_RD_REQ: begin
        m00_axi_arvalid = 1'b1;
        if (m00_axi_arready) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        m00_axi_rready = 1'b1;
        if (m00_axi_rvalid) state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge m00_axi_aclk or posedge m00_axi_areset) begin
    if (m00_axi_areset) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      rdata_q    <= '0;
      resp_q     <= '0;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      if (state_d != state_q) begin
        wait_cnt_q <= '0;
      end else if (waiting && wait_cnt_q != TIMEOUT_LIMIT) begin
        wait_cnt_q <= wait_cnt_q + 16'd1;
        if (wait_cnt_q + 16'd1 == TIMEOUT_LIMIT) timeout_q <= 1'b1;
      end

      if (accept) begin
        addr_q    <= cmd_addr;
        wdata_q   <= cmd_wdata;
        wstrb_q   <= cmd_wstrb;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
        timeout_q <= 1'b0;
      end else if (state_q == S_WR_REQ) begin
        aw_done_q <= aw_done_q | (m00_axi_awvalid & m00_axi_awready);
        w_done_q  <= w_done_q  | (m00_axi_wvalid  & m00_axi_wready);
      end

      if (state_q == S_WR_RESP && m00_axi_bvalid) begin
        rdata_q <= '0;
        resp_q  <= m00_axi_bresp;
      end
      if (state_q == S_RD_DATA && m00_axi_rvalid) begin
        rdata_q <= m00_axi_rdata;
        resp_q  <= m00_axi_rresp;
      end
    end
  end

endmodule

// File: tb/tb_aes_axil_master.sv
// Directed bench for aes_axil_master: vector table driven through a
// cycle-indexed slave model, plus reset and corner-case sequences.
module tb_aes_axil_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        timeout;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  always #5 clk = ~clk;

  aes_axil_master #(
    .C_M_AXI_ADDR_WIDTH(32),
    .C_M_AXI_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .m00_axi_aclk(clk), .m00_axi_areset(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .timeout(timeout),
    .m00_axi_awaddr(awaddr), .m00_axi_awprot(awprot), .m00_axi_awvalid(awvalid),
    .m00_axi_awready(awready), .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb),
    .m00_axi_wvalid(wvalid), .m00_axi_wready(wready), .m00_axi_bresp(bresp),
    .m00_axi_bvalid(bvalid), .m00_axi_bready(bready), .m00_axi_araddr(araddr),
    .m00_axi_arprot(arprot), .m00_axi_arvalid(arvalid), .m00_axi_arready(arready),
    .m00_axi_rdata(rdata), .m00_axi_rresp(rresp), .m00_axi_rvalid(rvalid),
    .m00_axi_rready(rready)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Slave timing fields are cycle numbers after the accept edge (accept = cycle 0).
  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          aw_at, w_at, b_at, ar_at, r_at, rr_at;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    int          exp_rsp;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    logic        exp_to;
  } vec_t;

  logic h_awv[64], h_wv[64], h_bready[64], h_rsp_valid[64], h_cmd_ready[64], h_to[64];
  int   rsp_cyc;

  task automatic idle_inputs();
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    awready = 0; wready = 0; bvalid = 0; bresp = '0;
    arready = 0; rvalid = 0; rdata = '0; rresp = '0; rsp_ready = 0;
  endtask

  task automatic run_txn(input vec_t v);
    bit b_done = 0;
    bit r_done = 0;
    bit hs = 0;
    @(negedge clk);
    cmd_write = v.write; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
    cmd_valid = 1;
    #1 check("cmd_ready_before_accept", {31'd0, cmd_ready}, 1);
    @(posedge clk);
    rsp_cyc = -1;
    for (int c = 0; c < 64; c++) begin
      h_awv[c] = 0; h_wv[c] = 0; h_bready[c] = 0;
      h_rsp_valid[c] = 0; h_cmd_ready[c] = 0; h_to[c] = 0;
    end
    for (int k = 1; k < 64 && !hs; k++) begin
      @(negedge clk);
      cmd_valid = 0;
      awready   = (k >= v.aw_at);
      wready    = (k >= v.w_at);
      bvalid    = (k >= v.b_at) && !b_done;
      bresp     = v.bresp;
      arready   = (k >= v.ar_at);
      rvalid    = (k >= v.r_at) && !r_done;
      rdata     = v.rdata;
      rresp     = v.rresp;
      rsp_ready = (k >= v.rr_at);
      #1;
      h_awv[k] = awvalid; h_wv[k] = wvalid; h_bready[k] = bready;
      h_rsp_valid[k] = rsp_valid; h_cmd_ready[k] = cmd_ready; h_to[k] = timeout;
      if (k == 1) begin
        check("timeout_cleared_on_accept", {31'd0, timeout}, 0);
        if (v.write) begin
          check("awvalid_wvalid_c1", {30'd0, awvalid, wvalid}, 32'd3);
          check("awaddr_c1", awaddr, v.addr);
          check("wdata_c1", wdata, v.wdata);
          check("wstrb_c1", {28'd0, wstrb}, {28'd0, v.wstrb});
        end else begin
          check("arvalid_c1", {31'd0, arvalid}, 1);
          check("araddr_c1", araddr, v.addr);
        end
      end
      if (rsp_valid && rsp_cyc < 0) begin
        rsp_cyc = k;
        check("rsp_rdata", rsp_rdata, v.exp_rdata);
        check("rsp_resp", {30'd0, rsp_resp}, {30'd0, v.exp_resp});
        check("timeout_at_rsp", {31'd0, timeout}, {31'd0, v.exp_to});
      end
      if (bvalid && bready) b_done = 1;
      if (rvalid && rready) r_done = 1;
      if (rsp_valid && rsp_ready) hs = 1;
    end
    check("rsp_valid_cycle", rsp_cyc, v.exp_rsp);
    check("rsp_handshake_done", {31'd0, hs}, 1);
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
  endtask

  vec_t vecs[9];

  initial begin
    //           wr  addr         wdata         strb  aw  w   b   ar r   rr bresp rresp rdata         rsp rdata_exp     resp to
    vecs[0] = '{1'b1, 32'h10, 32'h00010203, 4'hF, 1,  1,  2,  0, 0,  0, 2'd0, 2'd0, 32'h0,        3, 32'h0,        2'd0, 1'b0};
    vecs[1] = '{1'b1, 32'h00, 32'h00000001, 4'hF, 4,  1,  5,  0, 0,  0, 2'd0, 2'd0, 32'h0,        6, 32'h0,        2'd0, 1'b0};
    vecs[2] = '{1'b0, 32'h30, 32'h0,        4'h0, 0,  0,  0,  2, 5,  9, 2'd0, 2'd0, 32'h69c4e0d8, 6, 32'h69c4e0d8, 2'd0, 1'b0};
    vecs[3] = '{1'b0, 32'h44, 32'h0,        4'h0, 0,  0,  0,  1, 2,  5, 2'd0, 2'd2, 32'hdeadbeef, 3, 32'hdeadbeef, 2'd2, 1'b0};
    vecs[4] = '{1'b1, 32'h20, 32'ha5a50f0f, 4'h3, 1,  1,  4,  0, 0,  0, 2'd2, 2'd0, 32'h0,        5, 32'h0,        2'd2, 1'b0};
    vecs[5] = '{1'b0, 32'h40, 32'h0,        4'h0, 0,  0,  0,  1, 2,  0, 2'd0, 2'd0, 32'h00000001, 3, 32'h00000001, 2'd0, 1'b0};
    vecs[6] = '{1'b1, 32'h14, 32'h04050607, 4'hF, 1,  3,  4,  0, 0,  0, 2'd0, 2'd0, 32'h0,        5, 32'h0,        2'd0, 1'b0};
    vecs[7] = '{1'b1, 32'h00, 32'h00000003, 4'hF, 21, 1,  22, 0, 0,  0, 2'd0, 2'd0, 32'h0,        23, 32'h0,       2'd0, 1'b1};
    vecs[8] = '{1'b0, 32'h34, 32'h0,        4'h0, 0,  0,  0,  1, 2,  0, 2'd0, 2'd0, 32'h12345678, 3, 32'h12345678, 2'd0, 1'b0};

    idle_inputs();
    rst = 1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 0);
    check("rst_valids", {27'd0, awvalid, wvalid, arvalid, rsp_valid, timeout}, 0);
    check("rst_readies", {30'd0, bready, rready}, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_resp", {30'd0, rsp_resp}, 0);
    check("rst_awaddr", awaddr, 0);
    check("prot", {26'd0, awprot, arprot}, 0);
    @(negedge clk);
    rst = 0;
    #1 check("cmd_ready_after_release", {31'd0, cmd_ready}, 1);

    for (int i = 0; i < 9; i++) begin
      run_txn(vecs[i]);
      case (i)
        1: begin
          check("wvalid_c1", {31'd0, h_wv[1]}, 1);
          check("wvalid_drop_c2", {31'd0, h_wv[2]}, 0);
          check("awvalid_hold_c4", {31'd0, h_awv[4]}, 1);
          check("awvalid_drop_c5", {31'd0, h_awv[5]}, 0);
          check("bready_low_c4", {31'd0, h_bready[4]}, 0);
          check("bready_rise_c5", {31'd0, h_bready[5]}, 1);
        end
        2: for (int c = 6; c <= 9; c++)
             check("rsp_valid_held", {31'd0, h_rsp_valid[c]}, 1);
        3: begin
          for (int c = 3; c <= 5; c++)
            check("cmd_ready_low_in_resp", {31'd0, h_cmd_ready[c]}, 0);
          #1 check("cmd_ready_after_rsp", {31'd0, cmd_ready}, 1);
        end
        7: begin
          check("timeout_low_early", {31'd0, h_to[5]}, 0);
          check("timeout_set", {31'd0, h_to[12]}, 1);
          check("awvalid_held_in_timeout", {31'd0, h_awv[20]}, 1);
        end
        default: ;
      endcase
    end

    // Reset asserted while waiting for B.
    @(negedge clk);
    cmd_write = 1; cmd_addr = 32'h18; cmd_wdata = 32'h08090a0b; cmd_wstrb = 4'hF;
    cmd_valid = 1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 0; awready = 1; wready = 1;
    @(negedge clk);
    awready = 0; wready = 0;
    #1 check("bready_in_wr_resp", {31'd0, bready}, 1);
    rst = 1;
    #1;
    check("async_rst_valids", {28'd0, awvalid, wvalid, arvalid, rsp_valid}, 0);
    check("async_rst_readies", {29'd0, bready, rready, cmd_ready}, 0);
    @(negedge clk);
    rst = 0;
    #1;
    check("post_rst_cmd_ready", {31'd0, cmd_ready}, 1);
    check("post_rst_rsp_valid", {31'd0, rsp_valid}, 0);
    @(negedge clk);
    #1;
    check("post_rst_idle", {29'd0, cmd_ready, rsp_valid, bready}, 32'd4);
    check("post_rst_awaddr", awaddr, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
